// File: rtl/register_file.sv
// 16 x 16-bit general-purpose register file: one synchronous write port and
// two independent combinational read ports, each gated by its own enable.
module register_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Wen,
  input  logic [ADDR_W-1:0] WAddr,
  input  logic [DATA_W-1:0] WData,
  input  logic [ADDR_W-1:0] RAAddr,
  input  logic [ADDR_W-1:0] RBAddr,
  input  logic              RAen,
  input  logic              RBen,
  output logic [DATA_W-1:0] RAData,
  output logic [DATA_W-1:0] RBData
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Reset wins over a same-cycle write; no register is hard-wired to zero.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (Wen) begin
      regs[WAddr] <= WData;
    end
  end

  // Reads come straight from storage with no write bypass, so a same-address
  // write becomes visible only after the edge that commits it.
  assign RAData = RAen ? regs[RAAddr] : '0;
  assign RBData = RBen ? regs[RBAddr] : '0;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: expected read data is queued when a
// read is presented and popped for comparison once the outputs settle.
module tb_register_file;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic              Wen = 1'b0;
  logic [ADDR_W-1:0] WAddr = '0;
  logic [DATA_W-1:0] WData = '0;
  logic [ADDR_W-1:0] RAAddr = '0;
  logic [ADDR_W-1:0] RBAddr = '0;
  logic              RAen = 1'b0;
  logic              RBen = 1'b0;
  logic [DATA_W-1:0] RAData;
  logic [DATA_W-1:0] RBData;

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Rst(Rst), .Wen(Wen), .WAddr(WAddr), .WData(WData),
    .RAAddr(RAAddr), .RBAddr(RBAddr), .RAen(RAen), .RBen(RBen),
    .RAData(RAData), .RBData(RBData)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_b;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present a read on both ports, queue its expectation, compare after settle.
  task automatic read_ab(input string tag,
                         input logic [ADDR_W-1:0] a, input logic ae,
                         input logic [ADDR_W-1:0] b, input logic be,
                         input logic [DATA_W-1:0] exp_a,
                         input logic [DATA_W-1:0] exp_b);
    exp_t e;
    RAAddr = a; RAen = ae;
    RBAddr = b; RBen = be;
    e.tag = tag; e.exp_a = exp_a; e.exp_b = exp_b;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check({e.tag, "_a"}, RAData, e.exp_a);
    check({e.tag, "_b"}, RBData, e.exp_b);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data);
    @(negedge Clk);
    Wen = 1'b1; WAddr = addr; WData = data;
    @(posedge Clk);
    #1;
    Wen = 1'b0;
  endtask

  task automatic do_reset(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data);
    @(negedge Clk);
    Rst = 1'b1; Wen = we; WAddr = addr; WData = data;
    @(posedge Clk);
    #1;
    Rst = 1'b0; Wen = 1'b0;
  endtask

  initial begin
    // Initial reset, then a write that a second reset must wipe out.
    do_reset(1'b0, '0, '0);
    do_write(4'd3, 16'hBEEF);
    @(negedge Clk);
    read_ab("pre_rst", 4'd3, 1'b1, 4'd3, 1'b1, 16'hBEEF, 16'hBEEF);
    do_reset(1'b0, '0, '0);
    @(negedge Clk);
    read_ab("rst_clr", 4'd3, 1'b1, 4'd0, 1'b1, 16'h0000, 16'h0000);

    // Fill every register with I+0x10, then read back with B offset by 8.
    for (int i = 0; i < 16; i++) begin
      do_write(4'(i), 16'(i) + 16'h0010);
    end
    @(negedge Clk);
    for (int i = 0; i < 16; i++) begin
      read_ab($sformatf("fill%0d", i), 4'(i), 1'b1, 4'((i + 8) % 16), 1'b1,
              16'(i) + 16'h0010, 16'((i + 8) % 16) + 16'h0010);
    end

    // Write disabled: several edges presenting a write to reg 5.
    @(negedge Clk);
    Wen = 1'b0; WAddr = 4'd5; WData = 16'hFFFF;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    read_ab("wen_off", 4'd5, 1'b1, 4'd5, 1'b1, 16'h0015, 16'h0015);

    // Read enables gate each port independently.
    read_ab("en_b", 4'd7, 1'b0, 4'd7, 1'b1, 16'h0000, 16'h0017);
    read_ab("en_a", 4'd7, 1'b1, 4'd7, 1'b0, 16'h0017, 16'h0000);
    read_ab("en_none", 4'd7, 1'b0, 4'd7, 1'b0, 16'h0000, 16'h0000);

    // Read-during-write: old value before the edge, new value after it.
    @(negedge Clk);
    Wen = 1'b1; WAddr = 4'd2; WData = 16'hA5A5;
    read_ab("rdw_pre", 4'd2, 1'b1, 4'd9, 1'b1, 16'h0012, 16'h0019);
    @(posedge Clk);
    #1;
    Wen = 1'b0;
    read_ab("rdw_post", 4'd2, 1'b1, 4'd9, 1'b1, 16'hA5A5, 16'h0019);

    // Reset has priority over a write on the same edge.
    @(negedge Clk);
    read_ab("prio_pre", 4'd4, 1'b1, 4'd9, 1'b1, 16'h0014, 16'h0019);
    do_reset(1'b1, 4'd4, 16'h1234);
    @(negedge Clk);
    read_ab("rst_prio", 4'd4, 1'b1, 4'd9, 1'b1, 16'h0000, 16'h0000);

    // Registers are usable again after the mid-operation reset.
    do_write(4'd15, 16'h5A5A);
    @(negedge Clk);
    read_ab("post_rst", 4'd15, 1'b1, 4'd2, 1'b1, 16'h5A5A, 16'h0000);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
